// File: rtl/win_acc_16_unsigned_if.sv
// Product-in / sum-out handshake bundle for the windowed unsigned accumulator.
// The master drives products and consumes sums; the slave is the accumulator.
interface win_acc_16_unsigned_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 5
);
    logic [CNT_W-1:0] cfg_len;
    logic             acc_clr;
    logic             prod_valid;
    logic [15:0]      prod_data;
    logic             prod_ready;
    logic             sum_valid;
    logic [ACC_W-1:0] sum_data;
    logic             sum_ovf;
    logic             sum_ready;

    modport master (
        output cfg_len, acc_clr, prod_valid, prod_data, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_ovf
    );

    modport slave (
        input  cfg_len, acc_clr, prod_valid, prod_data, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_ovf
    );
endinterface

// File: rtl/win_acc_16_unsigned.sv
// Saturating unsigned accumulator: sums cfg_len+1 16-bit products, then holds the
// result on a valid/ready output until the downstream stage takes it.
module win_acc_16_unsigned #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    win_acc_16_unsigned_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             prod_ready;
    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum_ext;

    assign prod_ext   = ACC_W'(bus.prod_data);
    assign sum_ext    = {1'b0, acc_q} + {1'b0, prod_ext};
    assign prod_ready = (state_q != StHold) && !bus.acc_clr;
    assign accept     = bus.prod_valid && prod_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        if (bus.acc_clr) begin
            // Abort wins over any accept or handshake; a held sum is dropped.
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_d   = prod_ext;
                        cnt_d   = '0;
                        len_d   = bus.cfg_len;
                        ovf_d   = 1'b0;
                        state_d = (bus.cfg_len == '0) ? StHold : StAcc;
                    end
                end
                StAcc: begin
                    if (accept) begin
                        if (sum_ext[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_ext[ACC_W-1:0];
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == len_q) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (bus.sum_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.sum_valid  = (state_q == StHold);
    assign bus.sum_data   = acc_q;
    assign bus.sum_ovf    = ovf_q;

endmodule

// File: tb/tb_win_acc_16_unsigned.sv
// Drives identical stimulus into a 24-bit and a 16-bit accumulator and checks both
// against a queue-of-terms model with saturating totals.
module tb_win_acc_16_unsigned;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  cfg_len;
    logic        acc_clr;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        sum_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Model: products of the sum in progress, its target length, and whether it is held.
    int unsigned terms[$];
    int          want = 1;
    bit          holding = 1'b0;
    bit          fresh = 1'b1;

    always #5 clk = ~clk;

    win_acc_16_unsigned_if #(.ACC_W(24), .CNT_W(5)) if24 ();
    win_acc_16_unsigned_if #(.ACC_W(16), .CNT_W(5)) if16 ();

    assign if24.cfg_len    = cfg_len;
    assign if24.acc_clr    = acc_clr;
    assign if24.prod_valid = prod_valid;
    assign if24.prod_data  = prod_data;
    assign if24.sum_ready  = sum_ready;
    assign if16.cfg_len    = cfg_len;
    assign if16.acc_clr    = acc_clr;
    assign if16.prod_valid = prod_valid;
    assign if16.prod_data  = prod_data;
    assign if16.sum_ready  = sum_ready;

    win_acc_16_unsigned #(.ACC_W(24), .CNT_W(5)) u_dut24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if24.slave)
    );

    win_acc_16_unsigned #(.ACC_W(16), .CNT_W(5)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic pv, input logic [15:0] pd,
                       input logic [4:0] len, input logic sr);
        longint      total;
        logic [31:0] e24, e16;
        @(negedge clk);
        rst_n      = r;
        acc_clr    = c;
        prod_valid = pv;
        prod_data  = pd;
        cfg_len    = len;
        sum_ready  = sr;
        #1;
        check_eq("prod_ready24", 32'(if24.prod_ready), 32'(!holding && !c));
        check_eq("prod_ready16", 32'(if16.prod_ready), 32'(!holding && !c));
        check_eq("sum_valid24", 32'(if24.sum_valid), 32'(holding));
        check_eq("sum_valid16", 32'(if16.sum_valid), 32'(holding));
        if (holding) begin
            total = 0;
            foreach (terms[i]) total += longint'(terms[i]);
            e24 = (total > 64'hFF_FFFF) ? 32'hFF_FFFF : 32'(total);
            e16 = (total > 64'hFFFF) ? 32'hFFFF : 32'(total);
            check_eq("sum_data24", 32'(if24.sum_data), e24);
            check_eq("sum_ovf24", 32'(if24.sum_ovf), 32'(total > 64'hFF_FFFF));
            check_eq("sum_data16", 32'(if16.sum_data), e16);
            check_eq("sum_ovf16", 32'(if16.sum_ovf), 32'(total > 64'hFFFF));
        end else if (fresh) begin
            check_eq("rst_data24", 32'(if24.sum_data), 32'h0);
            check_eq("rst_ovf24", 32'(if24.sum_ovf), 32'h0);
            check_eq("rst_data16", 32'(if16.sum_data), 32'h0);
            check_eq("rst_ovf16", 32'(if16.sum_ovf), 32'h0);
        end
        @(posedge clk);
        if (!r) begin
            terms.delete();
            holding = 1'b0;
            fresh   = 1'b1;
        end else if (c) begin
            terms.delete();
            holding = 1'b0;
        end else if (holding) begin
            if (sr) begin
                holding = 1'b0;
                terms.delete();
            end
        end else if (pv) begin
            if (terms.size() == 0) want = int'(len) + 1;
            terms.push_back(int'(pd));
            fresh = 1'b0;
            if (terms.size() == want) holding = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1);
    endtask

    initial begin
        logic        r, c, pv, sr;
        logic [15:0] pd;
        logic [4:0]  len;

        rst_n = 1'b0; acc_clr = 1'b0; prod_valid = 1'b0; prod_data = '0;
        cfg_len = '0; sum_ready = 1'b0;
        repeat (2) @(posedge clk);

        cyc(1'b0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0);
        idle(2);

        // 4 x 65025 back-to-back: 0x03F804 at 24 bits, saturates at 16 bits
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 16'd65025, 5'd3, 1'b1);
        idle(2);

        // 0xFFFF + 1 saturates the 16-bit instance; next sum 2 + 3 is clean
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFF, 5'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'h0001, 5'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 5'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'h0002, 5'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'h0003, 5'd1, 1'b1);
        idle(2);

        // Single-term sum held for 5 cycles with products offered
        cyc(1'b1, 1'b0, 1'b1, 16'h1234, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 16'h5555, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1);
        idle(1);

        // Abort after two terms, then 1 + 2 + 3
        cyc(1'b1, 1'b0, 1'b1, 16'd100, 5'd2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'd200, 5'd2, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'd300, 5'd2, 1'b1);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'(i), 5'd2, 1'b1);
        idle(2);

        // Gaps between terms and a cfg_len change mid-sum
        cyc(1'b1, 1'b0, 1'b1, 16'd10, 5'd2, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 5'd7, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'd20, 5'd7, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'd0, 5'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'd30, 5'd0, 1'b1);
        idle(2);

        // Reset while holding, then a normal sum
        cyc(1'b1, 1'b0, 1'b1, 16'h00AB, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 16'd7, 5'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'd8, 5'd1, 1'b1);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) != 0);
            c   = ($urandom_range(0, 29) == 0);
            pv  = ($urandom_range(0, 9) < 7);
            pd  = ($urandom_range(0, 2) == 0) ? 16'hFFFF - 16'($urandom_range(0, 255))
                                              : 16'($urandom);
            len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 3));
            sr  = ($urandom_range(0, 9) < 6);
            cyc(r, c, pv, pd, len, sr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/win_acc_16_unsigned.md
WIN_ACC_16_UNSIGNED -- requirements
Module: win_acc_16_unsigned

Interface
REQ-001 SHALL have parameter ACC_W, default 24, the accumulator and sum width; legal range 16..32.
REQ-002 SHALL have parameter CNT_W, default 5, the width of the length field and the term counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port cfg_len, input, CNT_W bits: terms per sum minus 1; sampled only on the first accepted product of a sum.
REQ-006 SHALL have port acc_clr, input, 1 bit: synchronous abort of the sum in progress.
REQ-007 SHALL have port prod_valid, input, 1 bit: prod_data is valid.
REQ-008 SHALL have port prod_data, input, 16 bits: unsigned 8x8 product from the upstream multiplier.
REQ-009 SHALL have port prod_ready, output, 1 bit: the block accepts prod_data this cycle.
REQ-010 SHALL have port sum_valid, output, 1 bit: sum_data and sum_ovf are valid.
REQ-011 SHALL have port sum_data, output, ACC_W bits: the completed unsigned sum.
REQ-012 SHALL have port sum_ovf, output, 1 bit: the sum saturated.
REQ-013 SHALL have port sum_ready, input, 1 bit: the downstream stage accepts the sum.

Function
REQ-014 SHALL implement the states IDLE, ACC and HOLD.
REQ-015 SHALL count a product as accepted on a cycle with prod_valid=1, prod_ready=1 and acc_clr=0.
REQ-016 SHALL drive prod_ready = (state is IDLE or ACC) and acc_clr=0.
REQ-017 In IDLE, on an accept, SHALL load acc=zero-extended prod_data, term counter=0 and len_q=cfg_len, and clear the overflow flag.
REQ-018 From IDLE, on an accept, SHALL go to HOLD if cfg_len=0, else to ACC.
REQ-019 In ACC, on an accept, SHALL add zero-extended prod_data to acc and increment the term counter.
REQ-020 In ACC, on the accept that makes the term counter equal len_q, SHALL go to HOLD.
REQ-021 SHALL allow idle cycles (prod_valid=0) in ACC with no change to acc or the counter.
REQ-022 SHALL saturate: when the ACC_W+1-bit sum exceeds 2^ACC_W-1, acc SHALL become all-ones and the overflow flag SHALL set and stay set until the next sum starts.
REQ-023 SHALL drive sum_valid=1 only in HOLD, with sum_data=acc and sum_ovf=overflow flag, both stable while sum_valid=1 and sum_ready=0.
REQ-024 In HOLD, with sum_ready=1, SHALL complete the handshake and return to IDLE on the next edge.
REQ-025 SHALL accept no product in the cycle of the HOLD handshake.
REQ-026 SHALL yield one sum per cfg_len+1 accepts, with sum_valid rising one cycle after the final accept; the minimum gap between the last product of one sum and the first of the next is 2 cycles.
REQ-027 On acc_clr=1 in any state, SHALL go to IDLE on the next edge, discarding acc, counter and overflow flag; acc_clr has priority over a simultaneous prod_valid or sum_ready, and a pending sum is dropped.
REQ-028 SHALL ignore changes to cfg_len while in ACC or HOLD.
REQ-029 SHALL be purely unsigned, with no rounding and no truncation other than saturation.

Reset
REQ-030 When rst_n=0 at a clock edge, SHALL set state=IDLE, acc=0, term counter=0, len_q=0 and overflow flag=0.
REQ-031 During and after reset, SHALL present prod_ready=1 (when acc_clr=0), sum_valid=0, sum_data=0 and sum_ovf=0.
REQ-032 SHALL discard any in-progress or held sum when reset is asserted mid-operation, with no sum_valid pulse.

Verification
REQ-033 SHALL pass this case: ACC_W=24, cfg_len=3, products 65025 x4 back-to-back, sum_ready=1 -> sum_data=0x03F804, sum_ovf=0, sum_valid for 1 cycle, one cycle after the 4th accept.
REQ-034 SHALL pass this case: ACC_W=16, cfg_len=1, products 0xFFFF then 0x0001 -> sum_data=0xFFFF, sum_ovf=1; the next sum 0x0002+0x0003 -> 0x0005, sum_ovf=0.
REQ-035 SHALL pass this case: cfg_len=0, product 0x1234, sum_ready=0 for 5 cycles -> sum_valid held with 0x001234 stable, prod_ready=0 until after the handshake.
REQ-036 SHALL pass this case: cfg_len=2, accept 2 products, then acc_clr=1 with prod_valid=1 -> no sum_valid, prod_ready=0 that cycle; a new sum of 1+2+3 -> 6.
REQ-037 SHALL pass this case: cfg_len=2 with prod_valid gaps between terms 10, 20 and 30 -> sum_data=60, and a cfg_len change mid-sum has no effect.
REQ-038 SHALL pass this case: rst_n=0 for 1 cycle while in HOLD -> sum_valid=0, sum_data=0 next cycle; the following sum is correct.
